// File: rtl/trackball_quad.sv
// Trackball emulator: turns mouse deltas and joystick inputs into
// two quadrature encoder pairs stepped at a fixed prescaled rate.
module trackball_quad #(
   parameter int STEP_DIV = 3000,
   parameter int ACC_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mouse_strobe,
   input  logic signed [8:0] mouse_dx,
   input  logic signed [8:0] mouse_dy,
   input  logic             joy_l,
   input  logic             joy_r,
   input  logic             joy_u,
   input  logic             joy_d,
   input  logic             fast,
   output logic             xa,
   output logic             xb,
   output logic             ya,
   output logic             yb,
   output logic             busy
);

   localparam int CW = $clog2(STEP_DIV);
   localparam int SW = ((ACC_W > 9) ? ACC_W : 9) + 2;
   localparam logic [CW-1:0] LIM_N = CW'(STEP_DIV - 1);
   localparam logic [CW-1:0] LIM_F = CW'(STEP_DIV / 2 - 1);
   localparam logic signed [SW-1:0] SMAX = SW'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SW-1:0] SMIN = -SMAX;

   logic [CW-1:0]           count_q, count_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
   logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
   logic [1:0]              xph_q, xph_d;
   logic [1:0]              yph_q, yph_d;
   logic                    busy_q, busy_d;
   logic                    tick;
   logic [CW-1:0]           lim;
   logic [1:0]              dir_x, dir_y;

   // dir encoding: 2'b01 forward, 2'b10 backward, 2'b00 hold
   function automatic logic [1:0] dir_of(
      input logic signed [ACC_W-1:0] acc,
      input logic                    pos,
      input logic                    neg
   );
      if (acc > 0)              dir_of = 2'b01;
      else if (acc < 0)         dir_of = 2'b10;
      else if (pos && !neg)     dir_of = 2'b01;
      else if (neg && !pos)     dir_of = 2'b10;
      else                      dir_of = 2'b00;
   endfunction

   function automatic logic [1:0] ph_step(
      input logic [1:0] p,
      input logic       fwd
   );
      unique case (p)
         2'b00:   ph_step = fwd ? 2'b01 : 2'b10;
         2'b01:   ph_step = fwd ? 2'b11 : 2'b00;
         2'b11:   ph_step = fwd ? 2'b10 : 2'b01;
         default: ph_step = fwd ? 2'b00 : 2'b11;
      endcase
   endfunction

   // Step and add both use the pre-add value; result clamps symmetric.
   function automatic logic signed [ACC_W-1:0] acc_upd(
      input logic signed [ACC_W-1:0] acc,
      input logic                    stb,
      input logic signed [8:0]       d,
      input logic [1:0]              dir
   );
      logic signed [SW-1:0] s;
      s = SW'(acc);
      if (stb) s = s + SW'(d);
      if (acc != 0) begin
         if (dir == 2'b01)      s = s - SW'(1);
         else if (dir == 2'b10) s = s + SW'(1);
      end
      if (s > SMAX)      acc_upd = ACC_W'(SMAX);
      else if (s < SMIN) acc_upd = ACC_W'(SMIN);
      else               acc_upd = ACC_W'(s);
   endfunction

   always_comb begin
      lim     = fast ? LIM_F : LIM_N;
      tick    = (count_q >= lim);
      count_d = tick ? '0 : count_q + CW'(1);
      dir_x   = tick ? dir_of(acc_x_q, joy_r, joy_l) : 2'b00;
      dir_y   = tick ? dir_of(acc_y_q, joy_u, joy_d) : 2'b00;
      xph_d   = (dir_x != 2'b00) ? ph_step(xph_q, dir_x[0]) : xph_q;
      yph_d   = (dir_y != 2'b00) ? ph_step(yph_q, dir_y[0]) : yph_q;
      acc_x_d = acc_upd(acc_x_q, mouse_strobe, mouse_dx, dir_x);
      acc_y_d = acc_upd(acc_y_q, mouse_strobe, mouse_dy, dir_y);
      busy_d  = (acc_x_d != 0) || (acc_y_d != 0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         acc_x_q <= '0;
         acc_y_q <= '0;
         xph_q   <= 2'b00;
         yph_q   <= 2'b00;
         busy_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         acc_x_q <= acc_x_d;
         acc_y_q <= acc_y_d;
         xph_q   <= xph_d;
         yph_q   <= yph_d;
         busy_q  <= busy_d;
      end
   end

   assign xa   = xph_q[1];
   assign xb   = xph_q[0];
   assign ya   = yph_q[1];
   assign yb   = yph_q[0];
   assign busy = busy_q;

endmodule

// File: tb/tb_trackball_quad.sv
// Directed bench for trackball_quad with STEP_DIV=8, ACC_W=10.
module tb_trackball_quad;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mouse_strobe = 1'b0;
   logic signed [8:0] mouse_dx = '0;
   logic signed [8:0] mouse_dy = '0;
   logic joy_l = 1'b0, joy_r = 1'b0, joy_u = 1'b0, joy_d = 1'b0;
   logic fast = 1'b0;
   logic xa, xb, ya, yb, busy;

   int total = 0;
   int bad = 0;

   trackball_quad #(.STEP_DIV(8), .ACC_W(10)) dut (
      .clk(clk), .reset(reset),
      .mouse_strobe(mouse_strobe),
      .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
      .joy_l(joy_l), .joy_r(joy_r),
      .joy_u(joy_u), .joy_d(joy_d),
      .fast(fast),
      .xa(xa), .xb(xb), .ya(ya), .yb(yb),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input int dx, input int dy);
      mouse_strobe = 1'b1;
      mouse_dx = 9'(dx);
      mouse_dy = 9'(dy);
      clks(1);
      mouse_strobe = 1'b0;
      mouse_dx = '0;
      mouse_dy = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mouse_strobe = 1'b0;
      mouse_dx = '0;
      mouse_dy = '0;
      {joy_l, joy_r, joy_u, joy_d} = 4'b0;
      fast = 1'b0;
      clks(2);
      reset = 1'b0;
   endtask

   function automatic int xph();
      return int'({xa, xb});
   endfunction

   function automatic int yph();
      return int'({ya, yb});
   endfunction

   initial begin
      // reset state
      clks(2);
      chk("rst_x", xph(), 0);
      chk("rst_y", yph(), 0);
      chk("rst_busy", int'(busy), 0);

      // +3 on X: three forward steps, 8 clks apart
      do_reset();
      strobe(3, 0);
      chk("t1_acc3", int'(dut.acc_x_q), 3);
      chk("t1_busy1", int'(busy), 1);
      clks(6);
      chk("t1_e7_x", xph(), 0);
      clks(1);
      chk("t1_e8_x", xph(), 1);
      chk("t1_e8_acc", int'(dut.acc_x_q), 2);
      clks(7);
      chk("t1_e15_x", xph(), 1);
      clks(1);
      chk("t1_e16_x", xph(), 3);
      clks(8);
      chk("t1_e24_x", xph(), 2);
      chk("t1_e24_acc", int'(dut.acc_x_q), 0);
      chk("t1_e24_busy", int'(busy), 0);
      chk("t1_y", yph(), 0);

      // -2 then +5 on the first tick: decided from pre-add value
      do_reset();
      strobe(-2, 0);
      clks(6);
      strobe(5, 0);
      chk("t2_e8_x", xph(), 2);
      chk("t2_e8_acc", int'(dut.acc_x_q), 4);
      clks(8);
      chk("t2_e16_x", xph(), 0);
      clks(24);
      chk("t2_e40_x", xph(), 2);
      chk("t2_e40_acc", int'(dut.acc_x_q), 0);
      chk("t2_e40_busy", int'(busy), 0);

      // saturation, both axes on one tick
      do_reset();
      for (int i = 0; i < 6; i++) strobe(255, 0);
      chk("t3_satx", int'(dut.acc_x_q), 511);
      strobe(0, -256);
      chk("t3_accy", int'(dut.acc_y_q), -256);
      clks(1);
      chk("t3_e8_x", xph(), 1);
      chk("t3_e8_y", yph(), 2);
      chk("t3_e8_accx", int'(dut.acc_x_q), 510);
      chk("t3_e8_accy", int'(dut.acc_y_q), -255);
      strobe(0, -256);
      chk("t3_accy511", int'(dut.acc_y_q), -511);
      strobe(0, -256);
      chk("t3_saty", int'(dut.acc_y_q), -511);

      // joystick, fast rate
      do_reset();
      fast = 1'b1;
      joy_r = 1'b1;
      clks(3);
      chk("t4_e3_x", xph(), 0);
      clks(1);
      chk("t4_e4_x", xph(), 1);
      clks(16);
      chk("t4_e20_x", xph(), 1);
      chk("t4_busy", int'(busy), 0);
      joy_l = 1'b1;
      clks(8);
      chk("t4_lr_x", xph(), 1);
      {joy_l, joy_r} = 2'b00;
      joy_d = 1'b1;
      clks(4);
      chk("t4_d_y", yph(), 2);
      chk("t4_d_x", xph(), 1);
      chk("t4_busy2", int'(busy), 0);

      // reset mid-motion
      do_reset();
      strobe(9, 0);
      clks(15);
      chk("t5_x11", xph(), 3);
      chk("t5_acc7", int'(dut.acc_x_q), 7);
      reset = 1'b1;
      mouse_strobe = 1'b1;
      mouse_dx = 9'sd5;
      joy_r = 1'b1;
      clks(1);
      mouse_strobe = 1'b0;
      mouse_dx = '0;
      chk("t5_rst_x", xph(), 0);
      chk("t5_rst_acc", int'(dut.acc_x_q), 0);
      chk("t5_rst_busy", int'(busy), 0);
      clks(1);
      reset = 1'b0;
      clks(7);
      chk("t5_e7_x", xph(), 0);
      clks(1);
      chk("t5_e8_x", xph(), 1);

      // fast raised at count 5
      do_reset();
      joy_r = 1'b1;
      clks(5);
      chk("t6_e5_x", xph(), 0);
      fast = 1'b1;
      clks(1);
      chk("t6_e6_x", xph(), 1);
      clks(3);
      chk("t6_e9_x", xph(), 1);
      clks(1);
      chk("t6_e10_x", xph(), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trackball_quad.md
TRACKBALL_QUAD -- requirements
Module: trackball_quad

Interface
- REQ-001 Parameter STEP_DIV, default 3000: clock cycles per quadrature step at normal rate; legal values are even and ≥4.
- REQ-002 Parameter ACC_W, default 10: width of the signed pending-step accumulator for each axis.
- REQ-003 clk  in  1  system clock; the only clock in the block.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 mouse_strobe  in  1  single-cycle pulse marking a valid mouse_dx/mouse_dy pair.
- REQ-006 mouse_dx  in  9  signed X delta, two's complement; positive means right.
- REQ-007 mouse_dy  in  9  signed Y delta, two's complement; positive means up.
- REQ-008 joy_l, joy_r, joy_u, joy_d  in  1 each  digital direction inputs, active high.
- REQ-009 fast  in  1  1 halves the step period.
- REQ-010 xa, xb  out  1 each  X-axis quadrature pair, registered.
- REQ-011 ya, yb  out  1 each  Y-axis quadrature pair, registered.
- REQ-012 busy  out  1  1 while either accumulator is non-zero.

Function
- REQ-013 The prescaler shall count up each clk, with limit = fast ? STEP_DIV/2-1 : STEP_DIV-1.
- REQ-014 When count ≥ limit, tick shall be asserted for one cycle and the count shall return to 0; a fast change mid-count therefore never loses a tick.
- REQ-015 On each axis, phase {A,B} shall step forward as 00→01→11→10→00 and backward in the reverse order.
- REQ-016 Forward shall mean right for X and up for Y.
- REQ-017 Phase shall change only on a tick, by exactly one state; the outputs shall update on the clk edge that samples the tick.
- REQ-018 Step direction per axis on a tick:
  - accumulator > 0: forward;
  - accumulator < 0: backward;
  - accumulator = 0: joystick (X: joy_r alone → forward, joy_l alone → backward; Y likewise with joy_u/joy_d);
  - otherwise: no step.
- REQ-019 Opposing joystick inputs held together (l+r, or u+d) shall produce no step on that axis.
- REQ-020 A step taken from the accumulator shall move it one count toward zero; a joystick step shall leave the accumulator unchanged.
- REQ-021 On mouse_strobe, the sign-extended delta shall be added to the accumulator.
- REQ-022 When a strobe and a tick occur in the same cycle, the step direction shall be decided from the pre-add accumulator value.
- REQ-023 In that same-cycle case, the result shall be sat(acc + delta − stepdir), where stepdir is +1, −1 or 0.
- REQ-024 Saturation shall clamp to ±(2^(ACC_W−1)−1); −2^(ACC_W−1) shall never be stored.
- REQ-025 The two axes shall be fully independent; both may step on the same tick.
- REQ-026 busy shall be registered and equal (accX≠0)|(accY≠0) as of the current state.
- REQ-027 No other state shall exist: no FIFO, no handshake back-pressure; a strobe is always accepted.

Reset
- REQ-028 While reset=1, on each clk the block shall clear the prescaler to 0, both accumulators to 0, and all phases to 00.
- REQ-029 While reset=1, xa=xb=ya=yb=0 and busy=0.
- REQ-030 Strobes, joystick inputs and ticks shall be ignored while reset=1.
- REQ-031 After reset deasserts, the first tick shall occur on the (limit+1)th clk.
- REQ-032 A reset asserted mid-motion shall discard pending steps and return both phases to 00 on the next edge.

Verification
- REQ-033 STEP_DIV=8, fast=0, strobe dx=+3, dy=0 → X phase sequence 01,11,10, each 8 clks apart; accX 3→0; busy falls with the third step; Y holds at 00.
- REQ-034 Strobe dx=−2, then a strobe dx=+5 on the same cycle as the first tick → one backward step (phase 10); accX = −2+5+1 = +4; the following four ticks step forward.
- REQ-035 ACC_W=10: six strobes of dx=+255 → accX saturates at +511; issue dy=−256 → accY = −256; both axes step on the same ticks.
- REQ-036 joy_r=1 for 5 ticks with fast=1 → 5 forward X steps at 4-clk spacing; with joy_l=joy_r=1 → no X change; busy stays 0.
- REQ-037 Reset pulse when accX=+7, phase=11 → next edge: phase 00, accX 0, busy 0; the first tick comes limit+1 clks after release.
- REQ-038 fast toggled 0→1 while count=5 with STEP_DIV=8 (limit becomes 3) → tick on the next cycle, after which spacing is 4 clks.
